fp_normalize_round: RTL and testbench

Post-addition normalization and rounding stage for the multicycle single-precision floating-point unit. It sits directly downstream of the mantissa adder/multiplier output. It accepts one unnormalized 28-bit mantissa with sign and biased exponent, normalizes it one bit per cycle, and rounds to nearest-even. It then packs an IEEE-754 binary32 result with overflow, underflow and inexact flags, using a start/busy/done handshake.

---
 rtl/fp_normalize_round.sv | 140 ++++++++++++++
 tb/tb_fp_normalize_round.sv | 136 +++++++++++++
 2 files changed

// File: rtl/fp_normalize_round.sv
// Multicycle normalize / round-to-nearest-even / pack stage for binary32.
// One normalization shift per cycle; start/busy/done handshake.
module fp_normalize_round (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sign_in,
  input  logic [7:0]  exp_in,
  input  logic [27:0] mant_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        inexact
);
  typedef enum logic [2:0] {S_IDLE, S_NORM, S_ROUND, S_RENORM, S_DONE} state_e;

  state_e             state_q, state_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [27:0]        mant_q, mant_d;
  logic               rnd_inx_q, rnd_inx_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [31:0]        result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic               inx_q, inx_d;

  // Post-rounding carry fix-up feeding the classifier
  logic [27:0]        mant_rn;
  logic signed [9:0]  exp_rn;
  assign mant_rn = mant_q[27] ? {1'b0, mant_q[27:1]} : mant_q;
  assign exp_rn  = mant_q[27] ? exp_q + 10'sd1 : exp_q;

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    mant_d    = mant_q;
    rnd_inx_d = rnd_inx_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    inx_d     = inx_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sign_d  = sign_in;
          exp_d   = {2'b00, exp_in};
          mant_d  = mant_in;
          state_d = S_NORM;
        end
      end
      S_NORM: begin
        if (mant_q == 28'd0) begin
          result_d = {sign_q, 31'b0};
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
          inx_d    = 1'b0;
          state_d  = S_DONE;
        end else if (mant_q[27]) begin
          // keep the shifted-out bit folded into sticky
          mant_d = {1'b0, mant_q[27:2], mant_q[1] | mant_q[0]};
          exp_d  = exp_q + 10'sd1;
        end else if (!mant_q[26]) begin
          mant_d = {mant_q[26:0], 1'b0};
          exp_d  = exp_q - 10'sd1;
        end else begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        rnd_inx_d = |mant_q[2:0];
        if (mant_q[2] & (mant_q[1] | mant_q[0] | mant_q[3]))
          mant_d = mant_q + 28'd8;
        state_d = S_RENORM;
      end
      S_RENORM: begin
        if (exp_rn >= 10'sd255) begin
          result_d = {sign_q, 8'hFF, 23'b0};
          ovf_d    = 1'b1;
          unf_d    = 1'b0;
          inx_d    = rnd_inx_q;
        end else if (exp_rn <= 10'sd0) begin
          result_d = {sign_q, 31'b0};
          ovf_d    = 1'b0;
          unf_d    = 1'b1;
          inx_d    = 1'b1;
        end else begin
          result_d = {sign_q, exp_rn[7:0], mant_rn[25:3]};
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
          inx_d    = rnd_inx_q;
        end
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      mant_q    <= '0;
      rnd_inx_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      inx_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      mant_q    <= mant_d;
      rnd_inx_q <= rnd_inx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      inx_q     <= inx_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign inexact   = inx_q;
endmodule

// File: tb/tb_fp_normalize_round.sv
// Scoreboard bench for fp_normalize_round: expected result, flags and
// done cycle are queued at issue and checked when done pulses.
module tb_fp_normalize_round;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        sign_in = 1'b0;
  logic [7:0]  exp_in = '0;
  logic [27:0] mant_in = '0;
  logic        busy, done, overflow, underflow, inexact;
  logic [31:0] result;

  fp_normalize_round dut (
    .clk(clk), .reset(reset), .start(start), .sign_in(sign_in),
    .exp_in(exp_in), .mant_in(mant_in), .busy(busy), .done(done),
    .result(result), .overflow(overflow), .underflow(underflow),
    .inexact(inexact)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        ovf, unf, inx;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (reset && done) begin
      if (sb.size() == 0) chk("spurious_done", 32'd1, 32'd0);
      else begin
        mon_e = sb.pop_front();
        chk("result",    result,    mon_e.res);
        chk("overflow",  {31'b0, overflow},  {31'b0, mon_e.ovf});
        chk("underflow", {31'b0, underflow}, {31'b0, mon_e.unf});
        chk("inexact",   {31'b0, inexact},   {31'b0, mon_e.inx});
        chk("done_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic run_op(input logic s, input logic [7:0] e, input logic [27:0] m,
                        input logic [31:0] r, input logic o, input logic u,
                        input logic x, input int lat, input bit pulse);
    bit got = 0;
    @(negedge clk);
    chk("idle_busy", {31'b0, busy}, 32'd0);
    sign_in = s; exp_in = e; mant_in = m; start = 1'b1;
    sb.push_back('{res: r, ovf: o, unf: u, inx: x, cyc: cyc + 1 + lat});
    @(negedge clk);
    start = 1'b0;
    chk("busy_hi", {31'b0, busy}, 32'd1);
    for (int i = 0; i < 60 && !got; i++) begin
      if (done) got = 1;
      else begin
        if (pulse && i == 2) begin start = 1'b1; mant_in = 28'h6000000; end
        else start = 1'b0;
        @(negedge clk);
      end
    end
    start = 1'b0;
    if (!got) chk("timeout", 32'd0, 32'd1);
    @(negedge clk);
    chk("busy_lo", {31'b0, busy}, 32'd0);
    chk("held_result", result, r);
  endtask

  initial begin
    #2;
    chk("rst_busy",   {31'b0, busy}, 32'd0);
    chk("rst_done",   {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_flags",  {29'b0, overflow, underflow, inexact}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    //     sign  exp     mant          result         o  u  x  lat pulse
    run_op(1'b0, 8'd127, 28'h8000000, 32'h40000000, 0, 0, 0, 4,  0);
    run_op(1'b0, 8'd127, 28'h6000000, 32'h3FC00000, 0, 0, 0, 3,  0);
    run_op(1'b0, 8'd127, 28'h0000008, 32'h34000000, 0, 0, 0, 26, 1);
    run_op(1'b0, 8'd127, 28'h7FFFFFC, 32'h40000000, 0, 0, 1, 3,  0);
    run_op(1'b0, 8'd127, 28'h4000004, 32'h3F800000, 0, 0, 1, 3,  0);
    run_op(1'b0, 8'd254, 28'h8000000, 32'h7F800000, 1, 0, 0, 4,  0);
    run_op(1'b0, 8'd1,   28'h2000000, 32'h00000000, 0, 1, 1, 4,  0);
    run_op(1'b1, 8'd77,  28'h0000000, 32'h80000000, 0, 0, 0, 1,  0);
    run_op(1'b1, 8'd130, 28'h5000000, 32'hC1200000, 0, 0, 0, 3,  0);
    run_op(1'b0, 8'd127, 28'h800000C, 32'h40000001, 0, 0, 1, 4,  0);
    run_op(1'b0, 8'd127, 28'h8000001, 32'h40000000, 0, 0, 1, 4,  0);
    run_op(1'b0, 8'd0,   28'h4000000, 32'h00000000, 0, 1, 1, 3,  0);
    run_op(1'b0, 8'd127, 28'h6000000, 32'h3FC00000, 0, 0, 0, 3,  0);

    // abort a long operation with an asynchronous reset mid-cycle
    @(negedge clk);
    sign_in = 1'b0; exp_in = 8'd127; mant_in = 28'h0000008; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy",   {31'b0, busy}, 32'd0);
    chk("abort_done",   {31'b0, done}, 32'd0);
    chk("abort_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op(1'b0, 8'd127, 28'h8000000, 32'h40000000, 0, 0, 0, 4, 0);

    // start held high: second acceptance lands one edge after leaving DONE
    @(negedge clk);
    sign_in = 1'b0; exp_in = 8'd127; mant_in = 28'h6000000; start = 1'b1;
    sb.push_back('{res: 32'h3FC00000, ovf: 1'b0, unf: 1'b0, inx: 1'b0, cyc: cyc + 4});
    sb.push_back('{res: 32'h3FC00000, ovf: 1'b0, unf: 1'b0, inx: 1'b0, cyc: cyc + 9});
    repeat (10) @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
